// File: rtl/adc_capture_ctrl_if.sv
// adc_capture_ctrl_if
//   Sample-stream and FIFO-write bundle between the ADC front end, the capture
//   controller and the ADC FIFO.
//   adc_valid  : 1-cycle strobe, adc_code holds a new sample
//   adc_code   : ADC sample
//   fifo_full  : FIFO full flag
//   fifo_wr_en : FIFO write enable, one cycle per written sample
//   fifo_din   : FIFO write data
//   master = capture controller, slave = ADC/FIFO side.
interface adc_capture_ctrl_if #(
  parameter int PRECISION = 10
);
  logic                 adc_valid;
  logic [PRECISION-1:0] adc_code;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [PRECISION-1:0] fifo_din;

  modport master (
    input  adc_valid, adc_code, fifo_full,
    output fifo_wr_en, fifo_din
  );

  modport slave (
    output adc_valid, adc_code, fifo_full,
    input  fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
//   Sequences ADC sample capture into the ADC FIFO. The host arms a window of
//   N samples; the block waits for a trigger, then gates FIFO writes.
//   clk, rst         : sole clock; synchronous active-high reset
//   i_start/i_abort  : 1-cycle arm / cancel pulses (abort wins over start)
//   i_sample_count   : window length, latched at start
//   i_trig_mode      : 00 immediate, 01 rising level, 10 falling level, 11 ext
//   i_trig_level     : level threshold, latched at start
//   i_ext_trig       : external trigger level, clk-synchronous
//   i_decim          : (ADC_DECIM_EN only) keep every decim-th sample
//   bus              : sample stream in, FIFO write out (registered, 1 clk)
//   o_busy/o_done    : ARMED|CAPTURE / window completed
//   o_overflow       : sticky, a sample was dropped on fifo_full
//   o_captured       : samples written this window
//   o_state_dbg      : state encoding
//   Optional feature macro: ADC_DECIM_EN
module adc_capture_ctrl #(
  parameter int PRECISION = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CNT_WIDTH-1:0] i_sample_count,
  input  logic [1:0]           i_trig_mode,
  input  logic [PRECISION-1:0] i_trig_level,
  input  logic                 i_ext_trig,
`ifdef ADC_DECIM_EN
  input  logic [7:0]           i_decim,
`endif
  adc_capture_ctrl_if.master   bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic [CNT_WIDTH-1:0] o_captured,
  output logic [2:0]           o_state_dbg
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;

  logic [2:0]           r_state;
  logic [CNT_WIDTH-1:0] r_count, r_cnt, r_captured;
  logic [1:0]           r_mode;
  logic [PRECISION-1:0] r_level, r_prev, r_din;
  logic                 r_prev_vld, r_overflow, r_wr_en;

  logic                 w_trig, w_keep, w_take, w_write;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

`ifdef ADC_DECIM_EN
  logic [7:0] r_decim, r_ph;
  logic       w_decim_on;
  logic [7:0] w_ph_inc;
  assign w_decim_on = (r_decim > 8'd1);
  assign w_ph_inc   = r_ph + 8'd1;
  assign w_keep     = !w_decim_on || (r_ph == 8'd0);
`else
  assign w_keep = 1'b1;
`endif

  // Level modes need a previous sample; the first sample after arming only
  // primes r_prev.
  always_comb begin
    w_trig = 1'b0;
    case (r_mode)
      2'b00: w_trig = 1'b1;
      2'b01: w_trig = r_prev_vld && (r_prev < r_level) && (bus.adc_code >= r_level);
      2'b10: w_trig = r_prev_vld && (r_prev > r_level) && (bus.adc_code <= r_level);
      default: w_trig = i_ext_trig;
    endcase
  end

  // A taken sample occupies a window slot whether or not the FIFO accepts it.
  assign w_take    = !i_abort && bus.adc_valid &&
                     (((r_state == S_ARMED) && w_trig) || ((r_state == S_CAPTURE) && w_keep));
  assign w_write   = w_take && !bus.fifo_full;
  assign w_cnt_nxt = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_cnt      <= '0;
      r_captured <= '0;
      r_mode     <= 2'b00;
      r_level    <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_overflow <= 1'b0;
      r_wr_en    <= 1'b0;
      r_din      <= '0;
`ifdef ADC_DECIM_EN
      r_decim    <= 8'd0;
      r_ph       <= 8'd0;
`endif
    end else begin
      r_wr_en <= w_write;
      if (w_write) r_din <= bus.adc_code;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start && !i_abort) begin
            r_count    <= i_sample_count;
            r_mode     <= i_trig_mode;
            r_level    <= i_trig_level;
            r_cnt      <= '0;
            r_captured <= '0;
            r_overflow <= 1'b0;
            r_prev_vld <= 1'b0;
`ifdef ADC_DECIM_EN
            r_decim    <= i_decim;
`endif
            r_state    <= (i_sample_count == '0) ? S_DONE : S_ARMED;
          end
        end
        S_ARMED, S_CAPTURE: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (bus.adc_valid) begin
            if (r_state == S_ARMED) begin
              r_prev     <= bus.adc_code;
              r_prev_vld <= 1'b1;
            end
`ifdef ADC_DECIM_EN
            // Phase restarts at the trigger so the trigger sample is kept.
            if (r_state == S_ARMED)
              r_ph <= w_decim_on ? 8'd1 : 8'd0;
            else if (w_decim_on)
              r_ph <= (w_ph_inc == r_decim) ? 8'd0 : w_ph_inc;
`endif
            if (w_take) begin
              r_cnt <= w_cnt_nxt;
              if (bus.fifo_full) r_overflow <= 1'b1;
              else               r_captured <= r_captured + 1'b1;
              r_state <= (w_cnt_nxt == r_count) ? S_DONE : S_CAPTURE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fifo_wr_en = r_wr_en;
  assign bus.fifo_din   = r_din;
  assign o_busy         = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign o_done         = (r_state == S_DONE);
  assign o_overflow     = r_overflow;
  assign o_captured     = r_captured;
  assign o_state_dbg    = r_state;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
module tb_adc_capture_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, abort, ext_trig;
  logic [15:0] sample_count;
  logic [1:0]  trig_mode;
  logic [9:0]  trig_level;
  logic [7:0]  decim;
  logic        busy, done, overflow;
  logic [15:0] captured;
  logic [2:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] wq[$];

  always #5 clk = ~clk;

  adc_capture_ctrl_if #(.PRECISION(10)) bus ();

  adc_capture_ctrl #(.PRECISION(10), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .i_sample_count(sample_count), .i_trig_mode(trig_mode),
    .i_trig_level(trig_level), .i_ext_trig(ext_trig),
`ifdef ADC_DECIM_EN
    .i_decim(decim),
`endif
    .bus(bus), .o_busy(busy), .o_done(done), .o_overflow(overflow),
    .o_captured(captured), .o_state_dbg(state_dbg)
  );

  // Record every FIFO write seen.
  always @(negedge clk) if (bus.fifo_wr_en) wq.push_back(bus.fifo_din);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic st(input logic [15:0] cnt, input logic [1:0] mode,
                    input logic [9:0] lvl, input logic [7:0] dcm);
    start = 1'b1; sample_count = cnt; trig_mode = mode; trig_level = lvl; decim = dcm;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive one sample, check the write one clock later and its 1-cycle width.
  task automatic smp(input string tg, input logic [9:0] code, input logic full,
                     input logic ext, input logic exp_wr, input int gap);
    bus.adc_valid = 1'b1; bus.adc_code = code; bus.fifo_full = full; ext_trig = ext;
    @(negedge clk);
    bus.adc_valid = 1'b0; bus.fifo_full = 1'b0; ext_trig = 1'b0;
    chk({tg, "_wr"}, bus.fifo_wr_en, exp_wr);
    if (exp_wr) chk({tg, "_din"}, bus.fifo_din, code);
    @(negedge clk);
    chk({tg, "_wr1"}, bus.fifo_wr_en, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic chk_q(input string tg, input logic [9:0] e0, input logic [9:0] e1,
                       input logic [9:0] e2, input logic [9:0] e3, input int n);
    logic [9:0] ex[4];
    #2;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    chk({tg, "_nwr"}, wq.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_q%0d", tg, i), (i < wq.size()) ? {22'd0, wq[i]} : 32'hFFFF, {22'd0, ex[i]});
    wq.delete();
  endtask

  task automatic chk_st(input string tg, input logic [2:0] s, input logic b, input logic d,
                        input logic ov, input logic [15:0] cap);
    chk({tg, "_state"}, state_dbg, s);
    chk({tg, "_busy"}, busy, b);
    chk({tg, "_done"}, done, d);
    chk({tg, "_ovf"}, overflow, ov);
    chk({tg, "_cap"}, captured, cap);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ext_trig = 1'b0;
    sample_count = '0; trig_mode = '0; trig_level = '0; decim = '0;
    bus.adc_valid = 1'b0; bus.adc_code = '0; bus.fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    chk_st("rst", 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("rst_wr", bus.fifo_wr_en, 1'b0);
    chk("rst_din", bus.fifo_din, 10'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: immediate trigger, window of 4, valid every 3 clk
    st(16'd4, 2'b00, 10'd0, 8'd0);
    chk_st("t1_armed", 3'd1, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 6; i++)
      smp($sformatf("t1_s%0d", i), i[9:0], 1'b0, 1'b0, i <= 4, 1);
    chk_st("t1_end", 3'd3, 1'b0, 1'b1, 1'b0, 16'd4);
    chk_q("t1", 10'd1, 10'd2, 10'd3, 10'd4, 4);

    // 2: rising level trigger at 0x200
    st(16'd2, 2'b01, 10'h200, 8'd0);
    smp("t2_a", 10'h100, 1'b0, 1'b0, 1'b0, 0);
    smp("t2_b", 10'h1FF, 1'b0, 1'b0, 1'b0, 0);
    smp("t2_c", 10'h200, 1'b0, 1'b0, 1'b1, 0);
    smp("t2_d", 10'h300, 1'b0, 1'b0, 1'b1, 0);
    smp("t2_e", 10'h050, 1'b0, 1'b0, 1'b0, 0);
    chk_st("t2_end", 3'd3, 1'b0, 1'b1, 1'b0, 16'd2);
    chk_q("t2", 10'h200, 10'h300, 10'd0, 10'd0, 2);

    // 3: FIFO full on the 3rd sample; a start while busy is ignored
    st(16'd5, 2'b00, 10'd0, 8'd0);
    chk("t3_clr_done", done, 1'b0);
    smp("t3_s1", 10'd1, 1'b0, 1'b0, 1'b1, 0);
    smp("t3_s2", 10'd2, 1'b0, 1'b0, 1'b1, 0);
    st(16'd0, 2'b00, 10'd0, 8'd0);
    chk("t3_busy_start", state_dbg, 3'd2);
    smp("t3_s3", 10'd3, 1'b1, 1'b0, 1'b0, 0);
    chk("t3_ovf_sticky", overflow, 1'b1);
    smp("t3_s4", 10'd4, 1'b0, 1'b0, 1'b1, 0);
    chk("t3_notdone", done, 1'b0);
    smp("t3_s5", 10'd5, 1'b0, 1'b0, 1'b1, 0);
    chk_st("t3_end", 3'd3, 1'b0, 1'b1, 1'b1, 16'd4);
    chk_q("t3", 10'd1, 10'd2, 10'd4, 10'd5, 4);

    // 4: abort + start + valid in the same cycle during CAPTURE
    st(16'd10, 2'b00, 10'd0, 8'd0);
    chk("t4_ovf_clr", overflow, 1'b0);
    smp("t4_s1", 10'd1, 1'b0, 1'b0, 1'b1, 0);
    smp("t4_s2", 10'd2, 1'b0, 1'b0, 1'b1, 0);
    abort = 1'b1; start = 1'b1; sample_count = 16'd1;
    bus.adc_valid = 1'b1; bus.adc_code = 10'd3;
    @(negedge clk);
    abort = 1'b0; start = 1'b0; bus.adc_valid = 1'b0;
    chk("t4_state", state_dbg, 3'd0);
    chk("t4_wr", bus.fifo_wr_en, 1'b0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b0);
    smp("t4_s4", 10'd4, 1'b0, 1'b0, 1'b0, 0);
    chk("t4_idle", state_dbg, 3'd0);
    chk_q("t4", 10'd1, 10'd2, 10'd0, 10'd0, 2);

    // 5: reset mid-capture, then a zero-length window
    st(16'd10, 2'b00, 10'd0, 8'd0);
    smp("t5_s1", 10'd1, 1'b1, 1'b0, 1'b0, 0);
    bus.adc_valid = 1'b1; bus.adc_code = 10'd2;
    @(negedge clk);
    bus.adc_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_st("t5_rst", 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("t5_rst_wr", bus.fifo_wr_en, 1'b0);
    chk("t5_rst_din", bus.fifo_din, 10'd0);
    #2 wq.delete();
    @(negedge clk);
    st(16'd0, 2'b00, 10'd0, 8'd0);
    chk_st("t5_zero", 3'd3, 1'b0, 1'b1, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    chk("t5_zero_hold", done, 1'b1);
    chk_q("t5", 10'd0, 10'd0, 10'd0, 10'd0, 0);

    // 7: external trigger, window of 1
    st(16'd1, 2'b11, 10'd0, 8'd0);
    smp("t7_s1", 10'd7, 1'b0, 1'b0, 1'b0, 0);
    smp("t7_s2", 10'd8, 1'b0, 1'b1, 1'b1, 0);
    chk_st("t7_end", 3'd3, 1'b0, 1'b1, 1'b0, 16'd1);
    chk_q("t7", 10'd8, 10'd0, 10'd0, 10'd0, 1);

`ifdef ADC_DECIM_EN
    // 6: decimate by 3
    st(16'd3, 2'b00, 10'd0, 8'd3);
    for (int i = 10; i <= 18; i++)
      smp($sformatf("t6_s%0d", i), i[9:0], 1'b0, 1'b0, (i == 10) || (i == 13) || (i == 16), 0);
    chk_st("t6_end", 3'd3, 1'b0, 1'b1, 1'b0, 16'd3);
    chk_q("t6", 10'd10, 10'd13, 10'd16, 10'd0, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
